source_bus_serializer: RTL

// - Transmit end of the narrow source/sink bus link: takes a parallel word, drives it onto a
//   BUS_WIDTH-bit source_bus one beat per accepted cycle, LSB beat first.
// - The downstream sink (bus receiver / gate consumer) applies backpressure via bus_ready.
// - One clock; reset is asynchronous and active-high (clk, rst).

---
 rtl/source_bus_serializer.sv | 90 +++++++++
 1 files changed

// File: rtl/source_bus_serializer.sv
// source_bus_serializer
// Transmit end of the narrow source/sink link. A parallel word is accepted,
// then presented on source_bus one BUS_WIDTH-bit beat at a time, LSB beat
// first, under bus_valid/bus_ready flow control. A new word can be taken on
// the cycle the last beat is accepted, so back-to-back words have no bubble.
module source_bus_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [BUS_WIDTH-1:0]  source_bus,
   output logic                  bus_valid,
   output logic                  bus_last,
   input  logic                  bus_ready,
   output logic                  busy
);

   localparam int BEATS = DATA_WIDTH / BUS_WIDTH;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]            state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0]      counter;
   logic                  last_q;
   logic [CNT_W-1:0]      next_cnt;

   assign next_cnt = counter + 1'b1;

   // Outputs come straight from flops; only in_ready looks at live inputs.
   assign source_bus = shift_reg[BUS_WIDTH-1:0];
   assign bus_valid  = (state == SEND);
   assign bus_last   = last_q;
   assign busy       = bus_valid;
   assign in_ready   = (state == IDLE) | ((state == SEND) & last_q & bus_ready);

   // Word load, per-beat shift/count, and back-to-back reload on the last beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         counter   <= '0;
         last_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shift_reg <= in_data;
                  counter   <= '0;
                  last_q    <= (LAST_CNT == '0);
                  state     <= SEND;
               end
            end
            SEND: begin
               if (bus_ready) begin
                  if (last_q) begin
                     if (in_valid) begin
                        // Reload in the same cycle so the next word follows without a gap.
                        shift_reg <= in_data;
                        counter   <= '0;
                        last_q    <= (LAST_CNT == '0);
                     end else begin
                        // Shifting out the final beat leaves the bus at zero while idle.
                        shift_reg <= shift_reg >> BUS_WIDTH;
                        counter   <= '0;
                        last_q    <= 1'b0;
                        state     <= IDLE;
                     end
                  end else begin
                     shift_reg <= shift_reg >> BUS_WIDTH;
                     counter   <= next_cnt;
                     last_q    <= (next_cnt == LAST_CNT);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
